evr_rx_core: RTL and testbench
==============================

EVR_RX_CORE -- requirements
Module: evr_rx_core

Interface
REQ-001 The block SHALL have parameter TOD_SECONDS_WIDTH, default 32, giving the width of the seconds word carried by shift events.
REQ-002 The block SHALL have parameter HEARTBEAT_TIMEOUT_CYCLES, default 250000000 (2 s at 125 MHz), giving the heartbeat watchdog period.
REQ-003 The block SHALL have port evrRxClk, input, width 1: the recovered receive clock; all logic runs on its rising edge.
REQ-004 The block SHALL have port evrRxReset, input, width 1: reset, synchronous to evrRxClk and active-high.
REQ-005 The block SHALL have port evrRxLinkUp, input, width 1: transceiver aligned and decoding.
REQ-006 The block SHALL have port evrRxData, input, width 16: [15:8] is the distributed bus, [7:0] is the event/comma slot.
REQ-007 The block SHALL have port evrRxCharIsK, input, width 2: per-byte K-character flags.
REQ-008 The block SHALL have ports evrEventTDATA (output, width 8) and evrEventTVALID (output, width 1): the received event stream, which has no back-pressure.
REQ-009 The block SHALL have port evrDistributedBus, output, width 8: the registered distributed bus.
REQ-010 The block SHALL have ports evrSeconds (output, width TOD_SECONDS_WIDTH) and evrSecondsValid (output, width 1): the time of day latched at the last marker.
REQ-011 The block SHALL have port evrPPStoggle, output, width 1: inverts on every accepted TOD marker.
REQ-012 The block SHALL have port evrHeartbeatMissing, output, width 1: the heartbeat watchdog has expired.
REQ-013 The block SHALL have port evrSymbolErrors, output, width 16: a saturating count of illegal K usage.

Function
REQ-014 Low-byte classification SHALL be:
- K with value 0xBC: comma, discarded.
- K with any other value: symbol error.
- Non-K 0x00: idle, discarded.
- Non-K non-zero: event.
REQ-015 Each event SHALL produce evrEventTDATA equal to the code and evrEventTVALID high for exactly one cycle, with latency 1 cycle from input; codes 0x70/0x71/0x7A/0x7D SHALL also be forwarded.
REQ-016 evrEventTVALID SHALL be low on every non-event cycle; evrEventTDATA SHALL hold its last value.
REQ-017 evrDistributedBus SHALL load evrRxData[15:8] with latency 1 when evrRxLinkUp=1 and evrRxCharIsK[1]=0, and SHALL hold otherwise.
REQ-018 evrRxCharIsK[1]=1 SHALL count as one symbol error; a K error in both bytes in the same cycle SHALL count once.
REQ-019 evrSymbolErrors SHALL saturate at 0xFFFF.
REQ-020 TOD shift handling SHALL be: event 0x70 shifts 0 and event 0x71 shifts 1 into the LSB of the shift register (MSB first); the bit counter SHALL saturate at TOD_SECONDS_WIDTH+1.
REQ-021 On event 0x7D with bit count exactly TOD_SECONDS_WIDTH, the block SHALL set evrSeconds to the shift register and evrSecondsValid to 1.
REQ-022 On event 0x7D with any other bit count, the block SHALL set evrSecondsValid to 0 and leave evrSeconds unchanged.
REQ-023 On every event 0x7D the block SHALL clear the bit counter and toggle evrPPStoggle; all three marker updates SHALL appear in the same cycle as evrEventTVALID.
REQ-024 The watchdog SHALL reload to HEARTBEAT_TIMEOUT_CYCLES-1 on event 0x7A.
REQ-025 The watchdog SHALL otherwise decrement; on reaching 0 it SHALL set evrHeartbeatMissing to 1 and stop.
REQ-026 evrHeartbeatMissing SHALL clear in the cycle that 0x7A is emitted.
REQ-027 While evrRxLinkUp=0:
- no events, no symbol errors;
- bit counter held at 0;
- evrSecondsValid forced to 0;
- watchdog keeps running.
REQ-028 Simultaneous events cannot occur; a marker immediately after the 32nd shift bit SHALL be accepted.

Reset
REQ-029 While evrRxReset=1 the block SHALL drive every output to 0 except evrHeartbeatMissing, which SHALL be 1.
REQ-030 While evrRxReset=1 the watchdog SHALL be held at HEARTBEAT_TIMEOUT_CYCLES-1, and the shift register and bit counter SHALL be cleared.
REQ-031 Reset asserted mid-TOD-sequence SHALL discard partial bits; the first marker after reset SHALL therefore yield evrSecondsValid=0.

Structure
REQ-032 The event codes 0x70, 0x71, 0x7A, 0x7D, 0x00 and 0xBC SHALL be defined in the shared package evr_evg_pkg, which the transmitter also uses.
REQ-033 The TOD shift register, bit counter and marker latch SHALL be implemented in the single sub-module evr_tod_deserializer.

Verification
REQ-034 Bench scenario, event stream: stream 0x01, 0xBC(K), 0x00, 0x2A -> TVALID pulses on cycles 2 and 5 with TDATA 0x01 and 0x2A; no pulse for comma or idle.
REQ-035 Bench scenario, valid TOD: 32 shifts encoding 0x12345678 then 0x7D -> evrSeconds=0x12345678, evrSecondsValid=1, evrPPStoggle inverted.
REQ-036 Bench scenario, bad TOD counts: 31 shifts then 0x7D -> evrSecondsValid=0 and evrSeconds unchanged; 33 shifts then 0x7D -> the same.
REQ-037 Bench scenario, heartbeat watchdog: HEARTBEAT_TIMEOUT_CYCLES=100, 0x7A, then 99 idle cycles -> missing=0; 100th idle cycle -> missing=1; next 0x7A -> missing=0.
REQ-038 Bench scenario, symbol errors: K 0x1C in low byte, and charIsK[1]=1, each once -> evrSymbolErrors=2 and no events; after 70000 errors -> 0xFFFF.
REQ-039 Bench scenario, link drop: evrRxLinkUp dropped after 16 shift bits, restored, 32 shifts, marker -> evrSecondsValid=1 with only the post-restore value.

Source files
------------

// File: rtl/evr_evg_pkg.sv
// Event codes and receive-slot classification shared by the event receiver and transmitter.
package evr_evg_pkg;

  // Event codes with special meaning on the event slot.
  localparam logic [7:0] EvCodeIdle          = 8'h00;
  localparam logic [7:0] EvCodeSecondsZero   = 8'h70;
  localparam logic [7:0] EvCodeSecondsOne    = 8'h71;
  localparam logic [7:0] EvCodeHeartbeat     = 8'h7A;
  localparam logic [7:0] EvCodeSecondsMarker = 8'h7D;

  // K28.5 comma, the only K character legal on the link.
  localparam logic [7:0] KCodeComma = 8'hBC;

  typedef enum logic [1:0] {
    SlotIdle,
    SlotComma,
    SlotEvent,
    SlotSymbolError
  } slot_kind_e;

  // Classify the low (event/comma) byte of a received word.
  function automatic slot_kind_e classify_slot(input logic is_k, input logic [7:0] code);
    slot_kind_e kind;
    if (is_k) begin
      kind = (code == KCodeComma) ? SlotComma : SlotSymbolError;
    end else begin
      kind = (code == EvCodeIdle) ? SlotIdle : SlotEvent;
    end
    return kind;
  endfunction

endpackage

// File: rtl/evr_rx_core_if.sv
// Received event stream (AXI-Stream style, no back-pressure).
interface evr_rx_core_if;
  import evr_evg_pkg::*;

  logic [7:0] evrEventTDATA;
  logic       evrEventTVALID;

  // Producer side: the receive core.
  modport master (
    output evrEventTDATA,
    output evrEventTVALID
  );

  // Consumer side: whatever acts on received events.
  modport slave (
    input evrEventTDATA,
    input evrEventTVALID
  );

endinterface

// File: rtl/evr_tod_deserializer.sv
// Time-of-day deserializer: collects seconds bits from 0x70/0x71 events (MSB first) and
// latches them on the 0x7D marker when exactly the full word was received.
module evr_tod_deserializer
  import evr_evg_pkg::*;
#(
  parameter int unsigned TOD_SECONDS_WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         link_up_i,
  // Event accepted this cycle (pre-register), so marker updates line up with TVALID.
  input  logic                         ev_valid_i,
  input  logic [7:0]                   ev_code_i,
  output logic [TOD_SECONDS_WIDTH-1:0] seconds_o,
  output logic                         seconds_valid_o,
  output logic                         pps_toggle_o
);

  // Counter must reach Width+1 so over-long sequences stay distinguishable from exact ones.
  localparam int unsigned CntW = $clog2(TOD_SECONDS_WIDTH + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(TOD_SECONDS_WIDTH);
  localparam logic [CntW-1:0] CntMax  = CntW'(TOD_SECONDS_WIDTH + 1);

  logic [TOD_SECONDS_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic [TOD_SECONDS_WIDTH-1:0] seconds_q, seconds_d;
  logic                         seconds_valid_q, seconds_valid_d;
  logic                         pps_toggle_q, pps_toggle_d;

  // Next-state: shift bits in, latch or reject on marker, flush while the link is down.
  always_comb begin
    shift_d         = shift_q;
    cnt_d           = cnt_q;
    seconds_d       = seconds_q;
    seconds_valid_d = seconds_valid_q;
    pps_toggle_d    = pps_toggle_q;

    if (ev_valid_i) begin
      case (ev_code_i)
        EvCodeSecondsZero, EvCodeSecondsOne: begin
          shift_d = {shift_q[TOD_SECONDS_WIDTH-2:0], ev_code_i == EvCodeSecondsOne};
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        EvCodeSecondsMarker: begin
          if (cnt_q == CntFull) begin
            seconds_d       = shift_q;
            seconds_valid_d = 1'b1;
          end else begin
            seconds_valid_d = 1'b0;
          end
          cnt_d        = '0;
          pps_toggle_d = ~pps_toggle_q;
        end
        default: ;
      endcase
    end

    // Bits gathered across a link outage cannot be trusted.
    if (!link_up_i) begin
      cnt_d           = '0;
      seconds_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q         <= '0;
      cnt_q           <= '0;
      seconds_q       <= '0;
      seconds_valid_q <= 1'b0;
      pps_toggle_q    <= 1'b0;
    end else begin
      shift_q         <= shift_d;
      cnt_q           <= cnt_d;
      seconds_q       <= seconds_d;
      seconds_valid_q <= seconds_valid_d;
      pps_toggle_q    <= pps_toggle_d;
    end
  end

  assign seconds_o       = seconds_q;
  assign seconds_valid_o = seconds_valid_q;
  assign pps_toggle_o    = pps_toggle_q;

endmodule

// File: rtl/evr_rx_core.sv
// Event receiver core: decodes the event slot, registers the distributed bus, counts
// illegal K characters, runs the heartbeat watchdog and hosts the TOD deserializer.
module evr_rx_core
  import evr_evg_pkg::*;
#(
  parameter int unsigned TOD_SECONDS_WIDTH        = 32,
  parameter int unsigned HEARTBEAT_TIMEOUT_CYCLES = 250000000
) (
  input  logic                         evrRxClk,
  input  logic                         evrRxReset,
  input  logic                         evrRxLinkUp,
  input  logic [15:0]                  evrRxData,
  input  logic [1:0]                   evrRxCharIsK,
  evr_rx_core_if.master                evrEvent,
  output logic [7:0]                   evrDistributedBus,
  output logic [TOD_SECONDS_WIDTH-1:0] evrSeconds,
  output logic                         evrSecondsValid,
  output logic                         evrPPStoggle,
  output logic                         evrHeartbeatMissing,
  output logic [15:0]                  evrSymbolErrors
);

  localparam int unsigned WdW =
      (HEARTBEAT_TIMEOUT_CYCLES > 1) ? $clog2(HEARTBEAT_TIMEOUT_CYCLES) : 1;
  localparam logic [WdW-1:0] WdReload = WdW'(HEARTBEAT_TIMEOUT_CYCLES - 1);

  logic [7:0]  ev_code;
  slot_kind_e  slot_kind;
  logic        ev_valid;
  logic        sym_err;

  logic [7:0]     tdata_q, tdata_d;
  logic           tvalid_q, tvalid_d;
  logic [7:0]     dbus_q, dbus_d;
  logic [15:0]    sym_cnt_q, sym_cnt_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic           hb_missing_q, hb_missing_d;

  assign ev_code   = evrRxData[7:0];
  assign slot_kind = classify_slot(evrRxCharIsK[0], ev_code);

  // Slot decode; nothing is accepted or counted while the transceiver is not aligned.
  always_comb begin
    ev_valid = evrRxLinkUp && (slot_kind == SlotEvent);
    // A bad K in both bytes of the same word is one error, hence the OR.
    sym_err  = evrRxLinkUp && ((slot_kind == SlotSymbolError) || evrRxCharIsK[1]);
  end

  // Next-state for event stream, distributed bus, error counter and watchdog.
  always_comb begin
    tdata_d      = tdata_q;
    tvalid_d     = ev_valid;
    dbus_d       = dbus_q;
    sym_cnt_d    = sym_cnt_q;
    wd_d         = wd_q;
    hb_missing_d = hb_missing_q;

    if (ev_valid) begin
      tdata_d = ev_code;
    end

    if (evrRxLinkUp && !evrRxCharIsK[1]) begin
      dbus_d = evrRxData[15:8];
    end

    if (sym_err && (sym_cnt_q != 16'hFFFF)) begin
      sym_cnt_d = sym_cnt_q + 16'd1;
    end

    // Watchdog keeps running through link outages; parks at zero once expired.
    if (ev_valid && (ev_code == EvCodeHeartbeat)) begin
      wd_d         = WdReload;
      hb_missing_d = 1'b0;
    end else if (wd_q == '0) begin
      hb_missing_d = 1'b1;
    end else begin
      wd_d = wd_q - WdW'(1);
    end
  end

  // State registers with synchronous reset; heartbeat is reported missing until seen.
  always_ff @(posedge evrRxClk) begin
    if (evrRxReset) begin
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      dbus_q       <= '0;
      sym_cnt_q    <= '0;
      wd_q         <= WdReload;
      hb_missing_q <= 1'b1;
    end else begin
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      dbus_q       <= dbus_d;
      sym_cnt_q    <= sym_cnt_d;
      wd_q         <= wd_d;
      hb_missing_q <= hb_missing_d;
    end
  end

  evr_tod_deserializer #(
    .TOD_SECONDS_WIDTH(TOD_SECONDS_WIDTH)
  ) u_tod (
    .clk_i          (evrRxClk),
    .rst_i          (evrRxReset),
    .link_up_i      (evrRxLinkUp),
    .ev_valid_i     (ev_valid),
    .ev_code_i      (ev_code),
    .seconds_o      (evrSeconds),
    .seconds_valid_o(evrSecondsValid),
    .pps_toggle_o   (evrPPStoggle)
  );

  assign evrEvent.evrEventTDATA  = tdata_q;
  assign evrEvent.evrEventTVALID = tvalid_q;
  assign evrDistributedBus       = dbus_q;
  assign evrHeartbeatMissing     = hb_missing_q;
  assign evrSymbolErrors         = sym_cnt_q;

endmodule

// File: tb/tb_evr_rx_core.sv
// Testbench for evr_rx_core: directed vectors, a queue-based behavioural model compared
// every cycle, and literal expectations at the key points of each scenario.
module tb_evr_rx_core;

  localparam int unsigned W = 32;
  localparam int unsigned T = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        link = 1'b0;
  logic [15:0] data = '0;
  logic [1:0]  kflg = '0;

  logic [7:0]   dbus;
  logic [W-1:0] seconds;
  logic         secv;
  logic         pps;
  logic         missing;
  logic [15:0]  sym;

  evr_rx_core_if ev_if ();

  evr_rx_core #(
    .TOD_SECONDS_WIDTH       (W),
    .HEARTBEAT_TIMEOUT_CYCLES(T)
  ) dut (
    .evrRxClk           (clk),
    .evrRxReset         (rst),
    .evrRxLinkUp        (link),
    .evrRxData          (data),
    .evrRxCharIsK       (kflg),
    .evrEvent           (ev_if.master),
    .evrDistributedBus  (dbus),
    .evrSeconds         (seconds),
    .evrSecondsValid    (secv),
    .evrPPStoggle       (pps),
    .evrHeartbeatMissing(missing),
    .evrSymbolErrors    (sym)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit         m_live = 1'b0;
  bit         m_tvalid;
  logic [7:0] m_tdata;
  logic [7:0] m_dbus;
  logic [W-1:0] m_sec;
  bit         m_secv;
  bit         m_pps;
  int         m_sym;
  bit         m_hb_seen;
  int         m_since;
  bit         tod_bits[$];
  logic [7:0] m_lo;
  bit         m_hb_now;
  logic [W-1:0] m_fold;

  // Model: outputs after each rising edge, from the word presented before it.
  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1;
      m_tvalid = 0; m_tdata = 0; m_dbus = 0; m_sec = 0; m_secv = 0; m_pps = 0;
      m_sym = 0; m_hb_seen = 0; m_since = 0;
      tod_bits.delete();
    end else begin
      m_tvalid = 0;
      m_hb_now = 0;
      m_lo = data[7:0];
      if (link) begin
        if (kflg[1] || (kflg[0] && m_lo != 8'hBC)) begin
          if (m_sym < 65535) m_sym++;
        end
        if (!kflg[1]) m_dbus = data[15:8];
        if (!kflg[0] && m_lo != 8'h00) begin
          m_tvalid = 1;
          m_tdata  = m_lo;
          if (m_lo == 8'h70 || m_lo == 8'h71) begin
            tod_bits.push_back(m_lo == 8'h71);
            if (tod_bits.size() > W + 1) void'(tod_bits.pop_front());
          end else if (m_lo == 8'h7D) begin
            if (tod_bits.size() == W) begin
              m_fold = '0;
              foreach (tod_bits[i]) m_fold = {m_fold[W-2:0], tod_bits[i]};
              m_sec  = m_fold;
              m_secv = 1;
            end else begin
              m_secv = 0;
            end
            tod_bits.delete();
            m_pps = ~m_pps;
          end else if (m_lo == 8'h7A) begin
            m_hb_now = 1;
          end
        end
      end else begin
        tod_bits.delete();
        m_secv = 0;
      end
      if (m_hb_now) begin
        m_hb_seen = 1;
        m_since   = 0;
      end else if (m_since < int'(T)) begin
        m_since++;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("tvalid", 64'(ev_if.evrEventTVALID), 64'(m_tvalid));
      chk("tdata", 64'(ev_if.evrEventTDATA), 64'(m_tdata));
      chk("dbus", 64'(dbus), 64'(m_dbus));
      chk("seconds", 64'(seconds), 64'(m_sec));
      chk("secv", 64'(secv), 64'(m_secv));
      chk("pps", 64'(pps), 64'(m_pps));
      chk("missing", 64'(missing), 64'(!m_hb_seen || m_since >= int'(T)));
      chk("symerr", 64'(sym), 64'(m_sym));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit l, input logic [7:0] hi, input logic [7:0] lo,
                      input logic [1:0] kk);
    @(negedge clk);
    link = l;
    data = {hi, lo};
    kflg = kk;
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [7:0] code);
    step(1'b1, 8'h00, code, 2'b00);
  endtask

  task automatic tod_send(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) ev(v[i] ? 8'h71 : 8'h70);
  endtask

  initial begin
    // Reset with a marker on the wire: nothing may leak through.
    rst = 1'b1; link = 1'b1; data = {8'hAA, 8'h7D}; kflg = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(ev_if.evrEventTVALID), 64'd0);
    chk("rst_tdata", 64'(ev_if.evrEventTDATA), 64'd0);
    chk("rst_dbus", 64'(dbus), 64'd0);
    chk("rst_seconds", 64'(seconds), 64'd0);
    chk("rst_secv", 64'(secv), 64'd0);
    chk("rst_pps", 64'(pps), 64'd0);
    chk("rst_missing", 64'(missing), 64'd1);
    chk("rst_sym", 64'(sym), 64'd0);
    @(negedge clk);
    rst = 1'b0; data = '0;

    // Event stream: event, comma, idle, event.
    step(1'b1, 8'h55, 8'h01, 2'b00);
    chk("es_v1", 64'(ev_if.evrEventTVALID), 64'd1);
    chk("es_d1", 64'(ev_if.evrEventTDATA), 64'h01);
    chk("es_bus1", 64'(dbus), 64'h55);
    step(1'b1, 8'h66, 8'hBC, 2'b01);
    chk("es_comma_v", 64'(ev_if.evrEventTVALID), 64'd0);
    chk("es_comma_d", 64'(ev_if.evrEventTDATA), 64'h01);
    chk("es_comma_sym", 64'(sym), 64'd0);
    step(1'b1, 8'h77, 8'h00, 2'b00);
    chk("es_idle_v", 64'(ev_if.evrEventTVALID), 64'd0);
    step(1'b1, 8'h88, 8'h2A, 2'b00);
    chk("es_v2", 64'(ev_if.evrEventTVALID), 64'd1);
    chk("es_d2", 64'(ev_if.evrEventTDATA), 64'h2A);
    chk("es_bus2", 64'(dbus), 64'h88);
    ev(8'h00);
    chk("es_hold_d", 64'(ev_if.evrEventTDATA), 64'h2A);

    // Heartbeat watchdog.
    ev(8'h7A);
    chk("hb_clear", 64'(missing), 64'd0);
    chk("hb_fwd", 64'(ev_if.evrEventTDATA), 64'h7A);
    repeat (99) ev(8'h00);
    chk("hb_99", 64'(missing), 64'd0);
    ev(8'h00);
    chk("hb_100", 64'(missing), 64'd1);
    ev(8'h7A);
    chk("hb_again", 64'(missing), 64'd0);

    // Valid time of day.
    tod_send(64'h12345678, 32);
    ev(8'h7D);
    chk("tod_sec", 64'(seconds), 64'h12345678);
    chk("tod_v", 64'(secv), 64'd1);
    chk("tod_pps", 64'(pps), 64'd1);
    chk("tod_tv", 64'(ev_if.evrEventTVALID), 64'd1);

    // Short and long sequences are rejected.
    tod_send(64'hAAAAAAAA, 31);
    ev(8'h7D);
    chk("tod31_v", 64'(secv), 64'd0);
    chk("tod31_sec", 64'(seconds), 64'h12345678);
    chk("tod31_pps", 64'(pps), 64'd0);
    tod_send(64'h1_5555_5555, 33);
    ev(8'h7D);
    chk("tod33_v", 64'(secv), 64'd0);
    chk("tod33_sec", 64'(seconds), 64'h12345678);
    chk("tod33_pps", 64'(pps), 64'd1);

    // Link drop mid-sequence.
    tod_send(64'hCAFEF00D, 32);
    ev(8'h7D);
    chk("ld_pre_sec", 64'(seconds), 64'hCAFEF00D);
    tod_send(64'hFFFF, 16);
    step(1'b0, 8'h12, 8'h71, 2'b00);
    chk("ld_tv", 64'(ev_if.evrEventTVALID), 64'd0);
    chk("ld_secv", 64'(secv), 64'd0);
    chk("ld_bus", 64'(dbus), 64'h00);
    step(1'b0, 8'h13, 8'h1C, 2'b11);
    chk("ld_sym", 64'(sym), 64'd0);
    step(1'b0, 8'h00, 8'h7D, 2'b00);
    chk("ld_pps", 64'(pps), 64'd0);
    tod_send(64'h0BADBEEF, 32);
    ev(8'h7D);
    chk("ld_sec", 64'(seconds), 64'h0BADBEEF);
    chk("ld_v", 64'(secv), 64'd1);

    // Symbol errors.
    step(1'b1, 8'h00, 8'h1C, 2'b01);
    chk("se_1", 64'(sym), 64'd1);
    chk("se_1_tv", 64'(ev_if.evrEventTVALID), 64'd0);
    step(1'b1, 8'hEE, 8'h00, 2'b10);
    chk("se_2", 64'(sym), 64'd2);
    chk("se_2_tv", 64'(ev_if.evrEventTVALID), 64'd0);
    chk("se_2_bus", 64'(dbus), 64'h00);
    step(1'b1, 8'hEE, 8'h1C, 2'b11);
    chk("se_both", 64'(sym), 64'd3);
    repeat (70000) step(1'b1, 8'h00, 8'h1C, 2'b01);
    chk("se_sat", 64'(sym), 64'hFFFF);
    step(1'b1, 8'h00, 8'h00, 2'b10);
    chk("se_sat2", 64'(sym), 64'hFFFF);

    // Reset in the middle of a TOD sequence.
    tod_send(64'h1, 20);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_secv", 64'(secv), 64'd0);
    chk("mr_missing", 64'(missing), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    tod_send(64'h0, 12);
    ev(8'h7D);
    chk("mr_v", 64'(secv), 64'd0);
    chk("mr_sec", 64'(seconds), 64'd0);
    ev(8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
